// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Optional exception-flush support is enabled with the MD_CANCEL_EN macro.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned MD_W           = 32;
    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    // Counter only ever holds N-1, so max(N)+1 values is a safe bound.
    function automatic int unsigned md_cnt_width(int unsigned a, int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    localparam int unsigned MD_CNT_W = md_cnt_width(MD_MULT_CYCLES, MD_DIV_CYCLES);

endpackage

// File: rtl/md_if.sv
// EX-side bus of the multiply/divide sequencer: issue, mthi/mtlo and HI/LO results.
// The cancel strobe exists only when MD_CANCEL_EN is defined.
interface md_if
    import md_pkg::*;
#(
    parameter int unsigned W = MD_W
) ();

    logic         start;
    md_op_e       op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         hilo_we;
    logic         hilo_sel;
    logic [W-1:0] hilo_wdata;
    logic         busy;
    logic         stall_req;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MD_CANCEL_EN
    logic         cancel;
`endif

    modport master (
`ifdef MD_CANCEL_EN
        output cancel,
`endif
        output start, op, rs_val, rt_val, hilo_we, hilo_sel, hilo_wdata,
        input  busy, stall_req, hi, lo
    );

    modport slave (
`ifdef MD_CANCEL_EN
        input  cancel,
`endif
        input  start, op, rs_val, rt_val, hilo_we, hilo_sel, hilo_wdata,
        output busy, stall_req, hi, lo
    );

endinterface

// File: rtl/md_compute.sv
// Combinational MIPS mult/multu/div/divu datapath producing the {HI, LO} result.
// div0 flags a zero divisor so the sequencer can leave HI/LO untouched.
module md_compute
    import md_pkg::*;
#(
    parameter int unsigned W = MD_W
) (
    input  md_op_e       op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi_res,
    output logic [W-1:0] lo_res,
    output logic         div0
);

    logic [2*W-1:0] prod_s;
    logic [2*W-1:0] prod_u;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W-1:0]   b_div;
    logic [W-1:0]   q_mag;
    logic [W-1:0]   r_mag;
    logic           is_signed;
    logic           neg_q;
    logic           neg_r;

    assign prod_s = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    // Signed division runs on magnitudes; MIN / -1 then falls out as MIN with remainder 0.
    assign is_signed = (op == MD_DIV);
    assign a_mag     = (is_signed && a[W-1]) ? -a : a;
    assign b_mag     = (is_signed && b[W-1]) ? -b : b;
    assign div0      = (b == '0);
    assign b_div     = div0 ? {{(W-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag     = a_mag / b_div;
    assign r_mag     = a_mag % b_div;
    assign neg_q     = is_signed && (a[W-1] ^ b[W-1]);
    assign neg_r     = is_signed && a[W-1];

    always_comb begin
        hi_res = prod_u[2*W-1:W];
        lo_res = prod_u[W-1:0];
        unique case (op)
            MD_MULT: begin
                hi_res = prod_s[2*W-1:W];
                lo_res = prod_s[W-1:0];
            end
            MD_MULTU: begin
                hi_res = prod_u[2*W-1:W];
                lo_res = prod_u[W-1:0];
            end
            MD_DIV, MD_DIVU: begin
                hi_res = neg_r ? -r_mag : r_mag;
                lo_res = neg_q ? -q_mag : q_mag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Fixed-latency multiply/divide sequencer owning the HI/LO registers beside EX.
// Define MD_CANCEL_EN to add the exception-flush cancel input on the bus.
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned W           = MD_W,
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input logic clk,
    input logic reset_n,
    md_if.slave bus
);

    localparam int unsigned CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0] pend_hi_q, pend_hi_d;
    logic [W-1:0] pend_lo_q, pend_lo_d;
    logic         pend_div0_q, pend_div0_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;

    logic [W-1:0] hi_res;
    logic [W-1:0] lo_res;
    logic         div0;
    logic         cancel;
    logic         accept;
    logic         is_div;

`ifdef MD_CANCEL_EN
    assign cancel = bus.cancel;
`else
    assign cancel = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && bus.start && !cancel;
    assign is_div = (bus.op == MD_DIV) || (bus.op == MD_DIVU);

    md_compute #(
        .W (W)
    ) u_compute (
        .op     (bus.op),
        .a      (bus.rs_val),
        .b      (bus.rt_val),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_div0_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_div0_q <= pend_div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (cancel || (cnt_q == '0)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result is computed at issue and parked until the counter expires.
    always_comb begin
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_div0_d = pend_div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                cnt_d       = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                pend_hi_d   = hi_res;
                pend_lo_d   = lo_res;
                pend_div0_d = is_div && div0;
            end else if (bus.hilo_we && !bus.start) begin
                if (bus.hilo_sel) hi_d = bus.hilo_wdata;
                else              lo_d = bus.hilo_wdata;
            end
        end else if (cancel) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            if (!pend_div0_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        bus.busy      = (state_q == ST_BUSY);
        bus.stall_req = (state_q == ST_BUSY) || bus.start;
        bus.hi        = hi_q;
        bus.lo        = lo_q;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && (state_q == ST_BUSY) && bus.start)
            $display("md_ctrl: start while busy ignored at %0t", $time);
    end
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed MIPS cases plus randomized ops vs a 64-bit model.
// Compile with MD_CANCEL_EN to also exercise the cancel path.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_keep;
    int          exp_n;

    md_if #(.W(32)) bus ();

    md_ctrl #(
        .W           (32),
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (op)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                p  = {r[31:0], q[31:0]};
            end
            default: begin
                sa = longint'({32'b0, a});
                sb = longint'({32'b0, b});
                q  = sa / sb;
                r  = sa % sb;
                p  = {r[31:0], q[31:0]};
            end
        endcase
        return p;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the issue edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit with_we);
        logic [63:0] res;
        bus.start  = 1'b1;
        bus.op     = md_op_e'(op);
        bus.rs_val = a;
        bus.rt_val = b;
        if (with_we) begin
            bus.hilo_we    = 1'b1;
            bus.hilo_sel   = 1'b1;
            bus.hilo_wdata = 32'h5a5a_a5a5;
        end
        #1;
        check("stall_on_start", bus.stall_req, 1'b1);
        pend_keep = op[1] && (b == 32'h0);
        if (!pend_keep) begin
            res     = model(op, a, b);
            pend_hi = res[63:32];
            pend_lo = res[31:0];
        end
        exp_n = op[1] ? DC : MC;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.hilo_we = 1'b0;
    endtask

    // Counts busy cycles; returns at the first idle negedge after the commit.
    task automatic wait_done(input bit poke_lo);
        int cycles = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (cycles == 1) begin
                check("hi_mid_op", bus.hi, exp_hi);
                if (poke_lo) begin
                    bus.hilo_we    = 1'b1;
                    bus.hilo_sel   = 1'b0;
                    bus.hilo_wdata = 32'hdead_beef;
                end
            end
            if (poke_lo && cycles == 2) begin
                bus.hilo_we = 1'b0;
                check("lo_hold_busy", bus.lo, exp_lo);
            end
            @(negedge clk);
        end
        bus.hilo_we = 1'b0;
        if (!pend_keep) begin
            exp_hi = pend_hi;
            exp_lo = pend_lo;
        end
        check("busy_len", 64'(cycles), 64'(exp_n));
        check("busy_fall", bus.busy, 1'b0);
        check("hi_commit", bus.hi, exp_hi);
        check("lo_commit", bus.lo, exp_lo);
    endtask

    task automatic mtx(input bit sel, input logic [31:0] d);
        bus.hilo_we    = 1'b1;
        bus.hilo_sel   = sel;
        bus.hilo_wdata = d;
        #1;
        check("stall_idle_we", bus.stall_req, 1'b0);
        @(negedge clk);
        bus.hilo_we = 1'b0;
        if (sel) exp_hi = d;
        else     exp_lo = d;
        check("hi_mtx", bus.hi, exp_hi);
        check("lo_mtx", bus.lo, exp_lo);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        checks         = 0;
        errors         = 0;
        exp_hi         = '0;
        exp_lo         = '0;
        pend_keep      = 1'b0;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.op         = MD_MULT;
        bus.rs_val     = '0;
        bus.rt_val     = '0;
        bus.hilo_we    = 1'b0;
        bus.hilo_sel   = 1'b0;
        bus.hilo_wdata = '0;
`ifdef MD_CANCEL_EN
        bus.cancel     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_stall", bus.stall_req, 1'b0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);

        // Directed architectural cases.
        issue(2'b00, 32'hffff_ffff, 32'h2, 1'b0);
        wait_done(1'b0);
        check("mult_hi_const", bus.hi, 32'hffff_ffff);
        check("mult_lo_const", bus.lo, 32'hffff_fffe);
        issue(2'b01, 32'hffff_ffff, 32'h2, 1'b0);
        wait_done(1'b0);
        check("multu_hi_const", bus.hi, 32'h0000_0001);
        // Back-to-back: issue on the first idle cycle after commit.
        issue(2'b10, 32'hffff_fff9, 32'h2, 1'b0);
        wait_done(1'b0);
        check("div_lo_const", bus.lo, 32'hffff_fffd);
        check("div_hi_const", bus.hi, 32'hffff_ffff);
        issue(2'b11, 32'h7, 32'h0, 1'b1);
        wait_done(1'b0);
        check("divu0_hi_keep", bus.hi, 32'hffff_ffff);
        issue(2'b10, 32'h8000_0000, 32'hffff_ffff, 1'b0);
        wait_done(1'b0);
        check("div_ovf_lo", bus.lo, 32'h8000_0000);
        @(negedge clk);
        mtx(1'b1, 32'h0000_1234);
        issue(2'b00, 32'h0000_0003, 32'hffff_fffb, 1'b0);
        wait_done(1'b1);

        // Randomized ops with interleaved mthi/mtlo.
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'h0;
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hffff_ffff;
            end
            issue(rop, ra, rb, 1'b0);
            wait_done(1'b0);
            if ($urandom_range(0, 1) == 1) mtx(1'($urandom_range(0, 1)), $urandom);
        end

        // Asynchronous reset in the third busy cycle of a divide.
        issue(2'b10, 32'h0000_0064, 32'h0000_0007, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_hi", bus.hi, 32'h0);
        check("arst_lo", bus.lo, 32'h0);
        #1 reset_n = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        repeat (DC + 2) @(negedge clk);
        check("arst_no_commit_hi", bus.hi, 32'h0);
        check("arst_no_commit_lo", bus.lo, 32'h0);
        check("arst_idle", bus.busy, 1'b0);

`ifdef MD_CANCEL_EN
        mtx(1'b0, 32'h0000_0abc);
        issue(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0);
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", bus.busy, 1'b0);
        repeat (MC + 1) @(negedge clk);
        check("cancel_hi", bus.hi, exp_hi);
        check("cancel_lo", bus.lo, exp_lo);
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("cancel_start_busy", bus.busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
